rf_sequencer: RTL and testbench

RF_SEQUENCER -- requirements
Module: rf_sequencer

---
 rtl/rf_sequencer_pkg.sv | 27 ++
 rtl/rf_sequencer_alu.sv | 50 +++++
 rtl/rf_sequencer.sv | 152 +++++++++++++++
 tb/tb_rf_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_sequencer_pkg
// Description : Shared opcode constants and FSM state encoding for the
//               register-file sequencer and its ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_sequencer_pkg;

    localparam logic [2:0] OP_MOV  = 3'd0;  // result = A
    localparam logic [2:0] OP_LDI  = 3'd1;  // result = imm
    localparam logic [2:0] OP_ADD  = 3'd2;  // result = A + B
    localparam logic [2:0] OP_SUB  = 3'd3;  // result = A - B
    localparam logic [2:0] OP_AND  = 3'd4;  // result = A & B
    localparam logic [2:0] OP_OR   = 3'd5;  // result = A | B
    localparam logic [2:0] OP_XOR  = 3'd6;  // result = A ^ B
    localparam logic [2:0] OP_ADDI = 3'd7;  // result = A + imm

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rf_sequencer_alu.sv
`default_nettype none
// ============================================================================
// Module      : rf_alu
// Description : Combinational ALU for the register-file sequencer.
//               Ports: op (opcode), a/b (register operands), imm (immediate)
//               -> result (DW bits, wraps modulo 2^DW), carry (carry-out for
//               ADD/ADDI, borrow for SUB, 0 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module rf_alu
    import rf_sequencer_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [2:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] imm,
    output logic [DW-1:0] result,
    output logic          carry
);

    // One extra bit on each arithmetic path; the top bit is the carry or,
    // for subtraction, the borrow (set exactly when a < b unsigned).
    logic [DW:0] add_ab;
    logic [DW:0] add_ai;
    logic [DW:0] sub_ab;

    assign add_ab = {1'b0, a} + {1'b0, b};
    assign add_ai = {1'b0, a} + {1'b0, imm};
    assign sub_ab = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_MOV:  result = a;
            OP_LDI:  result = imm;
            OP_ADD:  begin result = add_ab[DW-1:0]; carry = add_ab[DW]; end
            OP_SUB:  begin result = sub_ab[DW-1:0]; carry = sub_ab[DW]; end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_ADDI: begin result = add_ai[DW-1:0]; carry = add_ai[DW]; end
            default: result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rf_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rf_sequencer
// Description : Four-cycle command sequencer driving an external register
//               file: IDLE (accept) -> READ -> EXEC -> WRITE.
//               Ports:
//                 clk, reset (async, active low)
//                 cmd_valid/cmd_ready handshake; cmd_op, cmd_dst, cmd_srca,
//                 cmd_srcb, cmd_imm command fields
//                 R_adr/S_adr read addresses, R/S read data (combinational)
//                 W_adr/W/we write port, done completion pulse,
//                 flags {C,N,Z} of the last written result
// Revision    : 1.0 - initial release
// ============================================================================
module rf_sequencer
    import rf_sequencer_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_dst,
    input  logic [AW-1:0] cmd_srca,
    input  logic [AW-1:0] cmd_srcb,
    input  logic [DW-1:0] cmd_imm,
    output logic [AW-1:0] W_adr,
    output logic          we,
    output logic [DW-1:0] W,
    output logic [AW-1:0] R_adr,
    output logic [AW-1:0] S_adr,
    input  logic [DW-1:0] R,
    input  logic [DW-1:0] S,
    output logic          done,
    output logic [2:0]    flags
);

    state_t        state;
    state_t        state_next;

    logic [2:0]    op_q;
    logic [AW-1:0] dst_q;
    logic [DW-1:0] imm_q;
    logic [DW-1:0] opa_q;
    logic [DW-1:0] opb_q;
    logic [DW-1:0] result_q;
    logic          carry_q;

    logic [DW-1:0] alu_result;
    logic          alu_carry;

    rf_alu #(
        .DW (DW)
    ) u_alu (
        .op     (op_q),
        .a      (opa_q),
        .b      (opb_q),
        .imm    (imm_q),
        .result (alu_result),
        .carry  (alu_carry)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_next = ST_READ;
            end
            ST_READ:  state_next = ST_EXEC;
            ST_EXEC:  state_next = ST_WRITE;
            ST_WRITE: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers. The read addresses are loaded on the accept
    // edge so they are already valid throughout READ, and then simply
    // hold. The write-port outputs are loaded on the EXEC->WRITE edge so
    // we/done are high for exactly the WRITE cycle; the write therefore
    // commits at the end of WRITE, before any following READ.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q     <= '0;
            dst_q    <= '0;
            imm_q    <= '0;
            R_adr    <= '0;
            S_adr    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            W_adr    <= '0;
            W        <= '0;
            we       <= 1'b0;
            done     <= 1'b0;
            flags    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        dst_q <= cmd_dst;
                        imm_q <= cmd_imm;
                        R_adr <= cmd_srca;
                        S_adr <= cmd_srcb;
                    end
                end
                ST_READ: begin
                    opa_q <= R;
                    opb_q <= S;
                end
                ST_EXEC: begin
                    result_q <= alu_result;
                    carry_q  <= alu_carry;
                    W_adr    <= dst_q;
                    W        <= alu_result;
                    we       <= 1'b1;
                    done     <= 1'b1;
                end
                ST_WRITE: begin
                    we    <= 1'b0;
                    done  <= 1'b0;
                    flags <= {carry_q, result_q[DW-1], (result_q == '0)};
                end
                default: begin
                    we   <= 1'b0;
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_sequencer
// Description : Self-checking bench for rf_sequencer paired with an 8x16
//               register file model. Directed table, held-valid, reset-abort
//               and randomized commands checked against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_dst;
    logic [2:0]  cmd_srca;
    logic [2:0]  cmd_srcb;
    logic [15:0] cmd_imm;
    logic [2:0]  W_adr;
    logic        we;
    logic [15:0] W;
    logic [2:0]  R_adr;
    logic [2:0]  S_adr;
    logic [15:0] R;
    logic [15:0] S;
    logic        done;
    logic [2:0]  flags;

    always #5 clk = ~clk;

    rf_sequencer #(
        .DW (16),
        .AW (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dst   (cmd_dst),
        .cmd_srca  (cmd_srca),
        .cmd_srcb  (cmd_srcb),
        .cmd_imm   (cmd_imm),
        .W_adr     (W_adr),
        .we        (we),
        .W         (W),
        .R_adr     (R_adr),
        .S_adr     (S_adr),
        .R         (R),
        .S         (S),
        .done      (done),
        .flags     (flags)
    );

    // Register file model (not cleared by the sequencer's reset)
    logic [15:0] rf [8] = '{default: 16'h0000};
    int          we_cnt = 0;
    assign R = rf[R_adr];
    assign S = rf[S_adr];
    always @(posedge clk) begin
        if (we) begin
            rf[W_adr] <= W;
            we_cnt    <= we_cnt + 1;
        end
    end

    // Reference state
    logic [15:0] exp_rf [8];
    int          exp_we;
    int          total;
    int          bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned 16-bit values
    function automatic void ref_exec(input logic [2:0] op, input int a, input int b,
                                     input int imm, output logic [15:0] res,
                                     output logic [2:0] f);
        int t;
        bit c;
        c = 1'b0;
        case (op)
            3'd0: t = a;
            3'd1: t = imm;
            3'd2: begin t = a + b;   c = (t > 65535); end
            3'd3: begin t = a - b;   c = (a < b); if (t < 0) t = t + 65536; end
            3'd4: t = a & b;
            3'd5: t = a | b;
            3'd6: t = a ^ b;
            default: begin t = a + imm; c = (t > 65535); end
        endcase
        t   = t % 65536;
        res = t[15:0];
        f   = {c, (t >= 32768), (t == 0)};
    endfunction

    // Issue one command starting at a negedge; ends at the negedge of the
    // IDLE cycle following WRITE.
    task automatic do_cmd(input logic [2:0] op, input logic [2:0] dst,
                          input logic [2:0] sa, input logic [2:0] sb,
                          input logic [15:0] imm, input logic [15:0] exp_w,
                          input logic [2:0] exp_f);
        int n;
        int lat;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("ready_timeout", 32'(cmd_ready), 32'd1);
            return;
        end
        cmd_op    = op;
        cmd_dst   = dst;
        cmd_srca  = sa;
        cmd_srcb  = sb;
        cmd_imm   = imm;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        chk("read_adr", 32'({R_adr, S_adr, cmd_ready}), 32'({sa, sb, 1'b0}));
        while (!we && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk("we_latency", 32'(lat), 32'd3);
        chk("w_adr", 32'(W_adr), 32'(dst));
        chk("w_data", 32'(W), 32'(exp_w));
        chk("done", 32'(done), 32'd1);
        @(negedge clk);
        chk("flags", 32'(flags), 32'(exp_f));
        chk("post_write", 32'({we, done, cmd_ready}), 32'b001);
        chk("rf_data", 32'(rf[dst]), 32'(exp_w));
        exp_rf[dst] = exp_w;
        exp_we++;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  dst;
        logic [2:0]  sa;
        logic [2:0]  sb;
        logic [15:0] imm;
        logic [15:0] ew;
        logic [2:0]  ef;
    } vec_t;

    vec_t tbl [15];

    initial begin
        logic [15:0] rres;
        logic [2:0]  rf_flags;
        logic [2:0]  rop, rdst, rsa, rsb;
        logic [15:0] rimm;
        int          acc;

        total = 0;
        bad   = 0;
        exp_we = 0;
        for (int i = 0; i < 8; i++) exp_rf[i] = 16'h0000;

        //                op    dst   sa    sb    imm       result    {C,N,Z}
        tbl[0]  = '{3'd1, 3'd3, 3'd0, 3'd0, 16'h1234, 16'h1234, 3'b000}; // LDI R3
        tbl[1]  = '{3'd1, 3'd1, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 3'b010}; // LDI R1
        tbl[2]  = '{3'd1, 3'd2, 3'd0, 3'd0, 16'h0001, 16'h0001, 3'b000}; // LDI R2
        tbl[3]  = '{3'd2, 3'd4, 3'd1, 3'd2, 16'h0000, 16'h0000, 3'b101}; // ADD R4
        tbl[4]  = '{3'd1, 3'd1, 3'd0, 3'd0, 16'h0005, 16'h0005, 3'b000}; // LDI R1
        tbl[5]  = '{3'd1, 3'd2, 3'd0, 3'd0, 16'h0007, 16'h0007, 3'b000}; // LDI R2
        tbl[6]  = '{3'd3, 3'd5, 3'd1, 3'd2, 16'h0000, 16'hFFFE, 3'b110}; // SUB R5
        tbl[7]  = '{3'd7, 3'd6, 3'd6, 3'd0, 16'h0001, 16'h0001, 3'b000}; // ADDI R6
        tbl[8]  = '{3'd7, 3'd6, 3'd6, 3'd0, 16'h0001, 16'h0002, 3'b000};
        tbl[9]  = '{3'd7, 3'd6, 3'd6, 3'd0, 16'h0001, 16'h0003, 3'b000};
        tbl[10] = '{3'd0, 3'd0, 3'd5, 3'd0, 16'h0000, 16'hFFFE, 3'b010}; // MOV
        tbl[11] = '{3'd6, 3'd7, 3'd5, 3'd5, 16'h0000, 16'h0000, 3'b001}; // XOR
        tbl[12] = '{3'd5, 3'd0, 3'd1, 3'd2, 16'h0000, 16'h0007, 3'b000}; // OR
        tbl[13] = '{3'd4, 3'd0, 3'd5, 3'd3, 16'h0000, 16'h1234, 3'b000}; // AND
        tbl[14] = '{3'd7, 3'd4, 3'd1, 3'd0, 16'hFFFB, 16'h0000, 3'b101}; // ADDI wrap

        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_dst   = 3'd0;
        cmd_srca  = 3'd0;
        cmd_srcb  = 3'd0;
        cmd_imm   = 16'h0000;

        // Reset state
        reset = 1'b0;
        #1;
        chk("reset_outs", 32'({we, done, W, W_adr, R_adr, S_adr, flags}), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(cmd_ready), 32'd1);

        // Directed table
        for (int i = 0; i < 15; i++) begin
            do_cmd(tbl[i].op, tbl[i].dst, tbl[i].sa, tbl[i].sb, tbl[i].imm,
                   tbl[i].ew, tbl[i].ef);
        end
        chk("r6_final", 32'(rf[6]), 32'h0003);

        // cmd_valid held for 10 cycles: accepted every fourth cycle
        cmd_op    = 3'd1;
        cmd_dst   = 3'd0;
        cmd_imm   = 16'h5A5A;
        cmd_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            chk("ready_hold", 32'(cmd_ready), 32'((i % 4) == 0));
            if (cmd_ready) acc++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("hold_accepts", 32'(acc), 32'd3);
        repeat (3) @(negedge clk);
        exp_rf[0] = 16'h5A5A;
        exp_we    = exp_we + 3;
        chk("hold_rf", 32'(rf[0]), 32'h5A5A);

        // Randomized commands against the reference model
        for (int i = 0; i < 40; i++) begin
            rop  = 3'($urandom_range(0, 7));
            rdst = 3'($urandom_range(0, 7));
            rsa  = 3'($urandom_range(0, 7));
            rsb  = 3'($urandom_range(0, 7));
            rimm = 16'($urandom);
            ref_exec(rop, int'(exp_rf[rsa]), int'(exp_rf[rsb]), int'(rimm), rres, rf_flags);
            do_cmd(rop, rdst, rsa, rsb, rimm, rres, rf_flags);
        end

        // Reset during EXEC of LDI R7,0xAAAA aborts without a write
        cmd_op    = 3'd1;
        cmd_dst   = 3'd7;
        cmd_srca  = 3'd2;
        cmd_srcb  = 3'd3;
        cmd_imm   = 16'hAAAA;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_outs", 32'({we, done, W, W_adr, R_adr, S_adr, flags}), 32'd0);
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_ready_after", 32'(cmd_ready), 32'd1);
        chk("abort_r7", 32'(rf[7]), 32'(exp_rf[7]));

        // Every write pulse accounted for; none from the aborted command
        repeat (2) @(negedge clk);
        chk("we_count", 32'(we_cnt), 32'(exp_we));
        for (int i = 0; i < 8; i++) chk("rf_final", 32'(rf[i]), 32'(exp_rf[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
